// File: rtl/milano_pkg.sv
// milano_pkg: shared types and defaults for the milano core pipeline control.
//   ctrl_state_e      : pipe_ctrl FSM states
//   MULDIV_CYCLES_DEF : default mul/div EX occupancy in cycles
package milano_pkg;
  typedef enum logic {CTRL_RUN = 1'b0, CTRL_MD_WAIT = 1'b1} ctrl_state_e;
  localparam int unsigned MULDIV_CYCLES_DEF = 4;
endpackage

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: combinational load-use hazard detection between ID and EX.
//   id_*_i : ID instruction validity, source addresses and usage flags
//   ex_*_i : EX destination, write enable and load flag
//   lu_o   : ID reads a register that the EX load has not yet produced
module pipe_hazard_unit (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wr_en_i,
  input  logic       ex_is_load_i,
  output logic       lu_o
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu_o = id_valid_i & ex_is_load_i & ex_rd_wr_en_i & (ex_rd_addr_i != 5'd0) &
                ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                 (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/hold/flush sequencing for PC, IF/ID, ID/EX and the mul/div unit.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   id_*_i, ex_*_i         : ID operand usage and EX instruction attributes
//   pc_stall_o, if_id_*_o  : front-end stall and bubble controls
//   id_ex_hold_o/flush_o   : ID/EX hold and bubble controls
//   muldiv_start_o/done_o  : mul/div start pulse and result-valid strobe
//   ctrl_state_o           : FSM state for debug
//   stall_cnt_o            : wrapping count of PC stall cycles
module pipe_ctrl
  import milano_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wr_en_i,
  input  logic        ex_is_load_i,
  input  logic        ex_is_muldiv_i,
  input  logic        ex_branch_taken_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_flush_o,
  output logic        muldiv_start_o,
  output logic        muldiv_done_o,
  output ctrl_state_e ctrl_state_o,
  output logic [31:0] stall_cnt_o
);
  localparam int unsigned CW = $clog2(MULDIV_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_CYCLES - 2);
  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          lu, run, br, md_start, lu_stall, busy, done;
  pipe_hazard_unit u_hazard (
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_rd_wr_en_i (ex_rd_wr_en_i),
    .ex_is_load_i  (ex_is_load_i),
    .lu_o          (lu)
  );
  // Priority in RUN: redirect kills ID, then mul/div start, then load-use bubble
  assign run      = state_q == CTRL_RUN;
  assign br       = run & ex_branch_taken_i;
  assign md_start = run & ~ex_branch_taken_i & ex_is_muldiv_i;
  assign lu_stall = run & ~ex_branch_taken_i & ~ex_is_muldiv_i & lu;
  assign busy     = ~run & (cnt_q != '0);
  assign done     = ~run & (cnt_q == '0);
  // Every output is gated by reset so nothing leaks out while rst_ni is low
  assign pc_stall_o     = rst_ni & (md_start | busy | lu_stall);
  assign if_id_stall_o  = rst_ni & (md_start | busy | lu_stall);
  assign if_id_flush_o  = rst_ni & br;
  assign id_ex_hold_o   = rst_ni & (md_start | busy);
  assign id_ex_flush_o  = rst_ni & (br | lu_stall);
  assign muldiv_start_o = rst_ni & md_start;
  assign muldiv_done_o  = rst_ni & done;
  assign ctrl_state_o   = rst_ni ? state_q : CTRL_RUN;
  assign stall_cnt_o    = rst_ni ? stall_cnt_q : 32'd0;
  always_comb begin
    state_d     = md_start ? CTRL_MD_WAIT : done ? CTRL_RUN : state_q;
    cnt_d       = md_start ? CNT_INIT : busy ? cnt_q - CW'(1) : cnt_q;
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall_o};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= CTRL_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;
  import milano_pkg::*;
  localparam int MC = 4;
  typedef struct packed {
    logic pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, start, done, st;
    logic [31:0] sc;
  } exp_t;
  logic clk_i = 0, rst_ni = 0;
  logic id_valid_i = 0, id_rs1_used_i = 0, id_rs2_used_i = 0;
  logic [4:0] id_rs1_addr_i = 0, id_rs2_addr_i = 0, ex_rd_addr_i = 0;
  logic ex_rd_wr_en_i = 0, ex_is_load_i = 0, ex_is_muldiv_i = 0, ex_branch_taken_i = 0;
  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o;
  logic muldiv_start_o, muldiv_done_o;
  ctrl_state_e ctrl_state_o;
  logic [31:0] stall_cnt_o;
  exp_t q[$];
  int checks = 0, errors = 0;
  int md_left = 0;
  logic [31:0] m_sc = 0;
  always #5 clk_i = ~clk_i;
  pipe_ctrl #(.MULDIV_CYCLES(MC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wr_en_i(ex_rd_wr_en_i),
    .ex_is_load_i(ex_is_load_i), .ex_is_muldiv_i(ex_is_muldiv_i),
    .ex_branch_taken_i(ex_branch_taken_i), .pc_stall_o(pc_stall_o),
    .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_hold_o(id_ex_hold_o), .id_ex_flush_o(id_ex_flush_o),
    .muldiv_start_o(muldiv_start_o), .muldiv_done_o(muldiv_done_o),
    .ctrl_state_o(ctrl_state_o), .stall_cnt_o(stall_cnt_o)
  );
  // One cycle: drive inputs, predict the cycle's outputs, advance the model
  task automatic step(input logic rst, input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic wr,
                      input logic ld, input logic md, input logic br);
    exp_t e;
    logic lu;
    @(negedge clk_i);
    rst_ni = rst; id_valid_i = idv; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_rs1_used_i = u1; id_rs2_used_i = u2; ex_rd_addr_i = rd; ex_rd_wr_en_i = wr;
    ex_is_load_i = ld; ex_is_muldiv_i = md; ex_branch_taken_i = br;
    e = '0;
    lu = idv && ld && wr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!rst) begin
      md_left = 0;
      m_sc = 0;
    end else begin
      e.st = md_left != 0;
      e.sc = m_sc;
      if (md_left == 0) begin
        if (br) begin
          e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (md) begin
          e.start = 1; e.id_ex_hold = 1; e.pc_stall = 1; e.if_id_stall = 1;
          md_left = MC - 1;
        end else if (lu) begin
          e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_flush = 1;
        end
      end else if (md_left == 1) begin
        e.done = 1;
        md_left = 0;
      end else begin
        e.id_ex_hold = 1; e.pc_stall = 1; e.if_id_stall = 1;
        md_left--;
      end
      m_sc = m_sc + (e.pc_stall ? 32'd1 : 32'd0);
    end
    q.push_back(e);
  endtask
  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Monitor: every cycle the DUT presents a full control vector; pop and compare
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && ctrl_state_o == CTRL_MD_WAIT && ex_branch_taken_i) begin
        errors++;
        $error("FAIL branch_in_md_wait: redirect seen while mul/div holds EX");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '{pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o,
              muldiv_start_o, muldiv_done_o, ctrl_state_o, stall_cnt_o};
        checks++;
        if (a[39:32] !== e[39:32]) begin
          errors++;
          $display("FAIL ctrl t=%0t got stall/if_stall/if_flush/hold/ex_flush/start/done/st=%b expected %b",
                   $time, a[39:32], e[39:32]);
        end
        checks++;
        if (a.sc !== e.sc) begin
          errors++;
          $display("FAIL stall_cnt t=%0t got %h expected %h", $time, a.sc, e.sc);
        end
      end
    end
  end
  initial begin
    logic [4:0] r1, r2, rd;
    logic b;
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
    idle();
    step(1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 7, 3, 1, 1, 3, 1, 1, 0, 1);
    idle();
    repeat (2 * MC + 1) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (MC) idle();
    idle();
    #3 force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFF;
    step(1, 1, 2, 9, 0, 1, 9, 1, 1, 0, 0);
    idle();
    for (int i = 0; i < 600; i++) begin
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      b = (md_left == 0) && ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 49) != 0, 1'($urandom), r1, r2, 1'($urandom), 1'($urandom), rd,
           1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, b);
    end
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk_i);
    #4;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the milano core.
- Generates stall, hold and flush controls for the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards between the ID and EX stages.
- Applies branch/jump redirect flushes.
- Sequences the multi-cycle mul/div unit in EX: start pulse, cycle counting, and holding the ID/EX register until the result is ready.

Parameters:
- MULDIV_CYCLES, 4, total EX occupancy in cycles of one mul/div op (start cycle included); legal range 2..64.

Ports:
- clk_i  in  1  clock, rising-edge active
- rst_ni  in  1  reset, synchronous, active-low
- id_valid_i  in  1  ID stage holds a valid instruction
- id_rs1_addr_i  in  5  ID source register 1 address
- id_rs2_addr_i  in  5  ID source register 2 address
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  5  EX destination register (from ID/EX)
- ex_rd_wr_en_i  in  1  EX writes rd
- ex_is_load_i  in  1  EX instruction is a load
- ex_is_muldiv_i  in  1  EX instruction is a mul/div op
- ex_branch_taken_i  in  1  EX resolves a taken branch/jump (redirect)
- pc_stall_o  out  1  PC keeps its value
- if_id_stall_o  out  1  IF/ID register keeps its contents
- if_id_flush_o  out  1  IF/ID loads a bubble
- id_ex_hold_o  out  1  ID/EX register keeps its contents
- id_ex_flush_o  out  1  ID/EX loads a bubble (rd_wr_en=0, ALU_NONE)
- muldiv_start_o  out  1  one-cycle start pulse to the mul/div unit
- muldiv_done_o  out  1  mul/div result is valid this cycle
- ctrl_state_o  out  1  FSM state (ctrl_state_e), for debug
- stall_cnt_o  out  32  count of cycles with pc_stall_o=1

Behaviour:
Reset
- While rst_ni=0, every output is forced to 0 combinationally.
- At the next clock edge with reset applied: state<=CTRL_RUN, cnt<=0, stall_cnt<=0.
- Reset asserted mid-operation (including CTRL_MD_WAIT) abandons the op; no done pulse is generated.

Load-use hazard (lu)
- lu = id_valid_i & ex_is_load_i & ex_rd_wr_en_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).

FSM: CTRL_RUN, CTRL_MD_WAIT; down-counter cnt of width $clog2(MULDIV_CYCLES).
- CTRL_RUN with ex_branch_taken_i=1:
  - if_id_flush_o=1, id_ex_flush_o=1, no stalls.
  - Redirect takes priority over lu; the ID instruction is killed.
- CTRL_RUN with ex_is_muldiv_i=1:
  - Outputs: muldiv_start_o=1, id_ex_hold_o=1, if_id_stall_o=1, pc_stall_o=1.
  - Update: cnt<=MULDIV_CYCLES-2, next state CTRL_MD_WAIT.
- CTRL_RUN with lu=1 (and neither case above):
  - pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly one cycle.
- CTRL_MD_WAIT with cnt!=0:
  - Holds and stalls stay asserted; cnt<=cnt-1; lu is ignored (no bubble while held).
- CTRL_MD_WAIT with cnt==0:
  - muldiv_done_o=1, all holds and stalls released, next state CTRL_RUN.
- MULDIV_CYCLES=2: CTRL_MD_WAIT is entered with cnt=0, so done occurs the cycle after start.
- Latency: hold/stall are asserted for exactly MULDIV_CYCLES-1 cycles; done occurs in cycle MULDIV_CYCLES.
- ex_branch_taken_i in CTRL_MD_WAIT is illegal: it is ignored, and the bench flags it by assertion.
- Back-to-back mul/div: ex_is_muldiv_i is re-evaluated only in CTRL_RUN, so the op following done starts on the next cycle.

Stall counter
- stall_cnt increments on every cycle with pc_stall_o=1 and wraps from 0xFFFF_FFFF to 0.
- stall_cnt_o is the registered value.

Decomposition:
- milano_pkg additions:
  - ctrl_state_e {CTRL_RUN, CTRL_MD_WAIT}
  - MULDIV_CYCLES_DEF = 4
- Sub-module pipe_hazard_unit: purely combinational lu detection, instantiated once.

Test Plan:
1. Load x5 in EX, ID add reads rs1=x5 -> one cycle of pc_stall/if_id_stall/id_ex_flush=1, then normal advance; stall_cnt_o 0->1.
2. Load with rd=x0, ID reads x0 -> no stall, no flush.
3. Taken branch in EX while lu=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0, stall_cnt unchanged.
4. MULDIV_CYCLES=4, mul in EX:
   - cycle 0: start=1, hold=1
   - cycles 1-2: hold=1
   - cycle 3: done=1, hold=0
   - stall_cnt_o=3; two back-to-back muls give start pulses 4 cycles apart.
5. rst_ni=0 during cycle 2 of a mul/div -> outputs 0 in that cycle; state CTRL_RUN and stall_cnt 0 after the edge; no done pulse.
6. Preload stall_cnt=0xFFFF_FFFF by forcing, one lu stall -> wraps to 0x0000_0000.
